// File: rtl/demux_1to7_buf_pkg.sv
// Shared datapath definitions for the buffered 1-to-7 demultiplexer.
package demux_1to7_buf_pkg;

  localparam int DATA_W       = 32;
  localparam int NUM_OUT      = 7;
  localparam int SEL_W        = 4;
  localparam int DEFAULT_SLOT = 0;

  // Out-of-range selects fall back to the default slot, matching the 7:1 select mux.
  function automatic logic [SEL_W-1:0] clamp_sel(input logic [SEL_W-1:0] sel);
    logic [SEL_W-1:0] max_sel;
    max_sel = SEL_W'(NUM_OUT - 1);
    return (sel <= max_sel) ? sel : SEL_W'(DEFAULT_SLOT);
  endfunction

endpackage

// File: rtl/demux_1to7_buf_slot.sv
// Single-entry output buffer: one word held under a valid/ready pair.
module demux_slot
  import demux_1to7_buf_pkg::*;
#(
  parameter int DATA_W = demux_1to7_buf_pkg::DATA_W
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_wr,
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_rd,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic              o_can_wr
);

  // A slot can be written when empty or when its consumer takes the word this cycle.
  assign o_can_wr = !o_valid | i_rd;

  // Occupancy: a refill wins over a drain so the slot stays full on a same-cycle swap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_valid <= 1'b0;
    end else if (i_wr) begin
      o_valid <= 1'b1;
    end else if (i_rd) begin
      o_valid <= 1'b0;
    end
  end

  // Data changes only on a write; it is held while full and after draining.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_data <= '0;
    end else if (i_wr) begin
      o_data <= i_data;
    end
  end

endmodule

// File: rtl/demux_1to7_buf.sv
// Buffered 1-to-7 demultiplexer: steers each accepted word into one of seven
// single-entry slots, each drained independently by its own consumer.
module demux_1to7_buf
  import demux_1to7_buf_pkg::*;
#(
  parameter int DATA_W  = demux_1to7_buf_pkg::DATA_W,
  parameter int NUM_OUT = demux_1to7_buf_pkg::NUM_OUT,
  parameter int SEL_W   = demux_1to7_buf_pkg::SEL_W
) (
  input  logic                      i_clk,
  input  logic                      i_rst_n,
  input  logic [DATA_W-1:0]         i_data,
  input  logic [SEL_W-1:0]          i_sel,
  input  logic                      i_valid,
  output logic                      o_ready,
  output logic [NUM_OUT*DATA_W-1:0] o_data,
  output logic [NUM_OUT-1:0]        o_valid,
  input  logic [NUM_OUT-1:0]        i_ready,
  output logic                      o_bad_sel
);

  localparam logic [SEL_W-1:0] MAX_SEL = SEL_W'(NUM_OUT - 1);

  logic [SEL_W-1:0]   tgt;
  logic               accept;
  logic [NUM_OUT-1:0] can_wr;
  logic [NUM_OUT-1:0] wr;

  assign tgt    = clamp_sel(i_sel);
  assign accept = i_valid & o_ready;

  // Ready follows the target slot's write permission; decoded by compare to avoid a wide index.
  always_comb begin
    o_ready = 1'b0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (tgt == SEL_W'(k)) begin
        o_ready = can_wr[k];
      end
    end
  end

  // ---- slot stage: one buffer per destination ----
  for (genvar k = 0; k < NUM_OUT; k++) begin : g_slot
    assign wr[k] = accept & (tgt == SEL_W'(k));

    demux_slot #(.DATA_W(DATA_W)) u_slot (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_wr     (wr[k]),
      .i_data   (i_data),
      .i_rd     (i_ready[k]),
      .o_valid  (o_valid[k]),
      .o_data   (o_data[k*DATA_W +: DATA_W]),
      .o_can_wr (can_wr[k])
    );
  end

  // One-cycle flag for an accepted word whose select was out of range.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_bad_sel <= 1'b0;
    end else begin
      o_bad_sel <= accept & (i_sel > MAX_SEL);
    end
  end

endmodule
